debug_poll_master: RTL and testbench

- Avalon-MM read master that periodically polls a 32-bit debug input register, such as a PIO input port, on one address.
- Each read sample is pushed into a small FIFO, optionally only when its value differs from the last pushed sample.
- The FIFO drains to a valid/ready stream for an HPS-side logger or on-chip trace buffer.
- Sits on the fabric as the initiator that reads the debug PIO slaves.

---
 rtl/debug_poll_pkg.sv | 10 +
 rtl/debug_poll_fifo.sv | 41 ++++
 rtl/debug_poll_master.sv | 100 ++++++++++
 tb/tb_debug_poll_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_poll_pkg.sv
// debug_poll_pkg: shared state encoding and constants for the debug poll master
package debug_poll_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam int DEPTH_DEF = 16;
    localparam logic [15:0] OVF_MAX = 16'hFFFF;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    localparam int PTR_W = ptr_w(DEPTH_DEF);
endpackage

// File: rtl/debug_poll_fifo.sv
// debug_poll_fifo: synchronous first-word fall-through sample FIFO
module debug_poll_fifo
    import debug_poll_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = ptr_w(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic w_wr, w_rd;
    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_rd    = i_pop & ~o_empty;
    // a pop in the same cycle frees the slot, so a push on a full FIFO still lands
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_data  = r_mem[r_rp[AW-1:0]];
    // storage write
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
    end
    // read/write pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end
endmodule

// File: rtl/debug_poll_master.sv
// debug_poll_master: periodic Avalon-MM read poller feeding a sample stream
module debug_poll_master
    import debug_poll_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  period,
    input  logic [ADDR_W-1:0] poll_addr,
    input  logic              change_only,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [15:0]       overflow_cnt,
    output logic              busy
);
    state_t r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_per_m1;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_cap, r_last, w_sample;
    logic r_have, r_last_v;
    logic [15:0] r_ovf;
    logic w_tick, w_accept, w_done, w_push, w_pop, w_full, w_empty, w_wr, w_drop;
    assign w_per_m1 = (period == '0) ? '0 : period - CNT_W'(1);
    // >= keeps the counter bounded if period shrinks below the current count
    assign w_tick   = enable && (r_cnt >= w_per_m1);
    assign w_accept = (r_state == REQ) && !avm_waitrequest;
    assign w_done   = (r_state == RESP) && (r_have || avm_readdatavalid);
    assign w_sample = r_have ? r_cap : avm_readdata;
    assign w_push   = w_done && (!change_only || !r_last_v || (w_sample != r_last));
    assign w_pop    = smp_valid && smp_ready;
    assign w_wr     = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign avm_read     = r_state == REQ;
    assign avm_address  = r_addr;
    assign busy         = r_state != IDLE;
    assign smp_valid    = !w_empty;
    assign overflow_cnt = r_ovf;
    // poll-period counter, held at zero while polling is disabled
    always_ff @(posedge clk) begin
        if (reset || !enable) r_cnt <= '0;
        else r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
    end
    // FSM state register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end
    // FSM next state; ticks outside IDLE are simply dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_tick) w_next = REQ;
            REQ:     if (!avm_waitrequest) w_next = RESP;
            RESP:    if (r_have || avm_readdatavalid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // address latch, early-data capture, last-pushed tracking and overflow count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_have   <= 1'b0;
            r_last_v <= 1'b0;
            r_ovf    <= '0;
        end else begin
            if ((r_state == IDLE) && w_tick) r_addr <= poll_addr;
            if (w_accept && avm_readdatavalid) begin
                r_cap  <= avm_readdata;
                r_have <= 1'b1;
            end else if (w_done) begin
                r_have <= 1'b0;
            end
            if (w_wr) begin
                r_last   <= w_sample;
                r_last_v <= 1'b1;
            end
            if (w_drop && (r_ovf != OVF_MAX)) r_ovf <= r_ovf + 16'd1;
        end
    end
    debug_poll_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_sample),
        .o_data  (smp_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_debug_poll_master.sv
// tb_debug_poll_master: directed checks of polling, stalls, filtering, overflow and reset
module tb_debug_poll_master;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 24;
    logic clk = 0, reset = 1, enable = 0, change_only = 0, smp_ready = 0;
    logic avm_waitrequest = 0, avm_readdatavalid = 0;
    logic [CNT_W-1:0] period = '0;
    logic [ADDR_W-1:0] poll_addr = '0, avm_address;
    logic [DATA_W-1:0] avm_readdata = '0, smp_data;
    logic avm_read, smp_valid, busy;
    logic [15:0] overflow_cnt;
    int n_checks = 0, n_errors = 0;
    int stall_cfg = 0, rsp_n = 0, cyc = 0;
    bit same_cycle = 0, stray_req = 0;
    logic [31:0] stray_data = '0;
    logic [31:0] rsp_arr [32];
    int issue_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    debug_poll_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .period            (period),
        .poll_addr         (poll_addr),
        .change_only       (change_only),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .smp_data          (smp_data),
        .smp_valid         (smp_valid),
        .smp_ready         (smp_ready),
        .overflow_cnt      (overflow_cnt),
        .busy              (busy)
    );
    initial forever #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    // records the cycle and address of every new read request
    initial begin
        logic prev;
        prev = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                issue_q.delete();
                addr_q.delete();
                prev = 0;
            end else begin
                if (avm_read && !prev) begin
                    issue_q.push_back(cyc);
                    addr_q.push_back(avm_address);
                end
                prev = avm_read;
            end
        end
    end
    // Avalon slave: stalls stall_cfg cycles, answers one cycle after accept (or with it)
    initial begin
        bit pend, in_req;
        int scnt, rsp_i;
        logic [31:0] pend_d, d;
        pend = 0; in_req = 0; scnt = 0; rsp_i = 0; pend_d = '0;
        forever begin
            @(posedge clk);
            #2;
            avm_readdatavalid = 0;
            if (reset) begin
                pend = 0;
                rsp_i = 0;
            end
            if (pend) begin
                avm_readdatavalid = 1;
                avm_readdata = pend_d;
                pend = 0;
            end
            if (stray_req) begin
                avm_readdatavalid = 1;
                avm_readdata = stray_data;
            end
            if (!avm_read) begin
                in_req = 0;
                avm_waitrequest = 0;
            end else begin
                if (!in_req) begin
                    in_req = 1;
                    scnt = stall_cfg;
                end
                if (scnt > 0) begin
                    avm_waitrequest = 1;
                    scnt--;
                end else begin
                    avm_waitrequest = 0;
                    d = (rsp_i < rsp_n) ? rsp_arr[rsp_i] : 32'hA5;
                    rsp_i++;
                    if (same_cycle) begin
                        avm_readdatavalid = 1;
                        avm_readdata = d;
                    end else begin
                        pend = 1;
                        pend_d = d;
                    end
                end
            end
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic reset_dut();
        reset = 1; enable = 0; smp_ready = 0; stray_req = 0; change_only = 0;
        same_cycle = 0; stall_cfg = 0; rsp_n = 0;
        tick_n(2);
        reset = 0;
    endtask
    task automatic wait_issues(input string tag, input int n);
        int t = 0;
        while (issue_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, issue_q.size(), n);
    endtask
    task automatic wait_rdv(input string tag);
        int t = 0;
        while (!avm_readdatavalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(avm_readdatavalid), 1);
    endtask
    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check({tag, "_v"}, 32'(smp_valid), 1);
        check(tag, smp_data, exp);
        smp_ready = 1;
        @(negedge clk);
        smp_ready = 0;
    endtask
    task automatic drain(output int n);
        n = 0;
        smp_ready = 1;
        repeat (24) begin
            if (smp_valid) n++;
            @(negedge clk);
        end
        smp_ready = 0;
    endtask
    // directed test sequence
    initial begin
        int n;
        reset = 1;
        tick_n(2);
        check("rst_read", 32'(avm_read), 0);
        check("rst_addr", 32'(avm_address), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(smp_valid), 0);
        check("rst_ovf", 32'(overflow_cnt), 0);
        reset = 0;
        // basic poll every 4 cycles
        period = 4; poll_addr = 2; enable = 1;
        wait_rdv("t1_rdv");
        check("t1_pre_valid", 32'(smp_valid), 0);
        @(negedge clk);
        check("t1_valid", 32'(smp_valid), 1);
        check("t1_data", smp_data, 32'hA5);
        wait_issues("t1_issues", 3);
        enable = 0;
        check("t1_gap01", issue_q[1] - issue_q[0], 4);
        check("t1_gap12", issue_q[2] - issue_q[1], 4);
        check("t1_addr0", 32'(addr_q[0]), 2);
        check("t1_addr2", 32'(addr_q[2]), 2);
        tick_n(6);
        drain(n);
        check("t1_count", n, 3);
        check("t1_empty", 32'(smp_valid), 0);
        // stall of 3 cycles with period 3: the tick inside the stall is dropped
        reset_dut();
        period = 3; poll_addr = 1; stall_cfg = 3; enable = 1;
        wait_issues("t2_issue1", 1);
        poll_addr = 3;
        for (int i = 0; i < 4; i++) begin
            check("t2_read", 32'(avm_read), 1);
            check("t2_addr", 32'(avm_address), 1);
            @(negedge clk);
        end
        check("t2_released", 32'(avm_read), 0);
        wait_issues("t2_issue2", 2);
        enable = 0;
        check("t2_gap", issue_q[1] - issue_q[0], 6);
        check("t2_addr1", 32'(addr_q[1]), 3);
        tick_n(10);
        drain(n);
        check("t2_count", n, 2);
        // change-only filtering
        reset_dut();
        change_only = 1; period = 1;
        rsp_arr[0] = 5; rsp_arr[1] = 5; rsp_arr[2] = 5;
        rsp_arr[3] = 7; rsp_arr[4] = 7; rsp_arr[5] = 5;
        rsp_n = 6; enable = 1;
        wait_issues("t3_issues", 6);
        enable = 0;
        tick_n(6);
        pop_expect("t3_a", 5);
        pop_expect("t3_b", 7);
        pop_expect("t3_c", 5);
        check("t3_empty", 32'(smp_valid), 0);
        // readdatavalid in the same cycle as the accept
        reset_dut();
        same_cycle = 1; period = 1;
        rsp_arr[0] = 11; rsp_arr[1] = 22; rsp_arr[2] = 33;
        rsp_n = 3; enable = 1;
        wait_issues("t3b_issues", 3);
        enable = 0;
        tick_n(6);
        pop_expect("t3b_a", 11);
        pop_expect("t3b_b", 22);
        pop_expect("t3b_c", 33);
        check("t3b_empty", 32'(smp_valid), 0);
        // overflow with consumer stalled, then push+pop on a full FIFO
        reset_dut();
        period = 1;
        for (int i = 0; i < 20; i++) rsp_arr[i] = i + 1;
        rsp_n = 20; enable = 1;
        wait_issues("t4_issues", 20);
        enable = 0;
        tick_n(6);
        check("t4_ovf", 32'(overflow_cnt), 4);
        check("t4_valid", 32'(smp_valid), 1);
        check("t4_head", smp_data, 1);
        rsp_arr[20] = 100; rsp_n = 21; enable = 1;
        wait_issues("t4_issue21", 21);
        enable = 0;
        wait_rdv("t4_rdv");
        smp_ready = 1;
        @(negedge clk);
        smp_ready = 0;
        check("t4_ovf_hold", 32'(overflow_cnt), 4);
        for (int i = 2; i <= 16; i++) pop_expect("t4_ord", i);
        pop_expect("t4_last", 100);
        check("t4_empty", 32'(smp_valid), 0);
        // reset while stalled in REQ, then a stray readdatavalid
        reset_dut();
        period = 1; stall_cfg = 10; enable = 1;
        wait_issues("t5_issue", 1);
        check("t5_busy_pre", 32'(busy), 1);
        reset = 1;
        @(negedge clk);
        check("t5_read", 32'(avm_read), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(smp_valid), 0);
        reset = 0; enable = 0; stall_cfg = 0;
        stray_data = 32'hDEAD; stray_req = 1;
        @(negedge clk);
        stray_req = 0;
        tick_n(3);
        check("t5_stray_valid", 32'(smp_valid), 0);
        check("t5_stray_busy", 32'(busy), 0);
        check("t5_stray_ovf", 32'(overflow_cnt), 0);
        // period 0 and 1 both issue as fast as the FSM allows
        for (int p = 0; p < 2; p++) begin
            reset_dut();
            period = CNT_W'(p); enable = 1;
            wait_issues("t6_issues", 4);
            enable = 0;
            check("t6_gap01", issue_q[1] - issue_q[0], 3);
            check("t6_gap23", issue_q[3] - issue_q[2], 3);
        end
        tick_n(6);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
